conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
Sequencing controller for the combinational 8x8x1 -> 6x6x3 conv datapath (3x3 kernel, 3 output channels, 8-bit elements).
- Accepts a byte stream on a valid/ready input and assembles the 27 weight bytes and 64 data bytes into the flat buses that drive the datapath.
- Waits a programmable settle time, then captures the 108 result bytes.
- Streams the results out on a valid/ready output.
- Sits between the host byte interface and the conv datapath instance.

Parameters:
SETTLE_CYC, 4, cycles data_lin is held stable before conv_lin is sampled; minimum 1.
CNT_W, 16, width of the picture counter.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
wt_load  input  1  sampled in IDLE; 1 selects a weight load
in_valid  input  1  input byte valid
in_ready  output  1  input byte accepted when in_valid & in_ready
in_data  input  8  input byte
data_lin  output  512  to datapath; byte i at [i*8 +: 8], i=0..63
weight_lin  output  216  to datapath; byte j at [j*8 +: 8], j=0..26
conv_lin  input  864  from datapath; byte k at [k*8 +: 8], k=0..107
out_valid  output  1  result byte valid
out_ready  input  1  result byte consumed when out_valid & out_ready
out_data  output  8  result byte
out_last  output  1  high with result byte 107
weight_ok  output  1  full weight set loaded
busy  output  1  FSM not in IDLE
pic_cnt  output  CNT_W  pictures completed; wraps modulo 2^CNT_W

Behaviour:
Reset values:
- All outputs 0, including data_lin, weight_lin, out_data, pic_cnt and weight_ok.
- Capture buffer is cleared; FSM is in IDLE.

FSM states: IDLE, LOAD_W, LOAD_D, WAIT, DRAIN.
- IDLE:
  - wt_load=1 -> LOAD_W (wt_load has priority).
  - Else if weight_ok=1 -> LOAD_D.
  - Else stay in IDLE.
  - in_ready=0.
- LOAD_W:
  - in_ready=1.
  - Each accepted byte is written to weight_lin[j*8 +: 8], with j counting 0..26.
  - weight_ok drops to 0 on entry.
  - After byte 26 is accepted: weight_ok=1 next cycle, go to IDLE.
- LOAD_D:
  - in_ready=1.
  - Accepted byte i is written to data_lin[i*8 +: 8], with i counting 0..63.
  - After byte 63 is accepted -> WAIT, settle counter loaded with SETTLE_CYC-1.
- WAIT:
  - in_ready=0; data_lin and weight_lin are held.
  - Counter decrements each cycle.
  - When the counter is 0: conv_lin is registered into the 864-bit capture buffer, output index k=0, go to DRAIN.
  - With SETTLE_CYC=N, conv_lin is sampled on the Nth edge after the edge that accepted byte 63.
- DRAIN:
  - out_valid=1; out_data=buf[k*8 +: 8]; out_last=(k==107).
  - On handshake, k increments.
  - On the handshake of k=107: pic_cnt++, go to IDLE; out_valid is 0 on the next cycle.
  - out_data/out_valid must stay stable while out_ready=0.

Boundary conditions:
- wt_load toggling outside IDLE is ignored.
- in_valid with in_ready=0 is dropped (not accepted).
- Index counters wrap only via state exit; no partial-picture flush.
- Asynchronous reset in any state returns immediately to reset values. Weights are lost; weight_ok=0.
- pic_cnt wraps from all-ones to 0.
- busy = (state != IDLE).

Optional Feature:
OVERLAP_EN
- Defined:
  - Output draining runs in an independent sub-FSM with an out_busy flag.
  - Main FSM returns from WAIT to IDLE immediately after capture, so LOAD_D of the next picture overlaps the drain.
  - The WAIT exit (capture) is additionally gated by out_busy=0. The settle counter holds at 0 until the previous drain completes.
  - pic_cnt increments on the last output handshake.
  - busy = (state != IDLE) | out_busy.
- Undefined: strictly serial behaviour as above; no overlap.

Test Plan:
- Reset then wt_load=1, weights 0x01..0x1B back-to-back -> weight_lin[7:0]=0x01, weight_lin[215:208]=0x1B, weight_ok=1 exactly one cycle after the 27th accept.
- 64 data bytes 0x00..0x3F with in_valid gaps every third cycle -> data_lin[511:504]=0x3F; conv_lin sampled exactly SETTLE_CYC=4 edges after the last accept (bench changes conv_lin on edge 3 vs edge 4 to prove it).
- Bench-supplied conv_lin with byte k = k -> out_data sequence 0..107, out_last only on 107, pic_cnt=1, state IDLE.
- out_ready toggled 1/0 every cycle during DRAIN -> no byte duplicated or skipped, out_data stable during stalls, 216 cycles to drain.
- Assert rst mid-LOAD_D at byte 30 -> all outputs 0 asynchronously, weight_ok=0; after release with wt_load=0 the FSM stays in IDLE.
- OVERLAP_EN: second picture fully loaded while the first drains with out_ready=0 -> capture stalls until the first drain finishes; both result streams are correct; pic_cnt=2.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: byte-stream sequencer for the 8x8x1 -> 6x6x3 conv datapath; define OVERLAP_EN to overlap the next data load with the result drain
module conv_seq_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wt_load,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [511:0]     data_lin,
  output logic [215:0]     weight_lin,
  input  logic [863:0]     conv_lin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             weight_ok,
  output logic             busy,
  output logic [CNT_W-1:0] pic_cnt
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_D, WAIT, DRAIN} state_t;
  state_t state;
  logic [4:0] wi;
  logic [5:0] di;
  logic [6:0] k;
  logic [SW-1:0] cnt;
  logic [863:0] cap;
  logic out_busy;
`ifdef OVERLAP_EN
  assign out_valid = out_busy;
  assign busy = (state != IDLE) | out_busy;
`else
  assign out_valid = state == DRAIN;
  assign busy = state != IDLE;
`endif
  assign in_ready = state == LOAD_W || state == LOAD_D;
  assign out_data = cap[k*8 +: 8];
  assign out_last = out_valid && k == 7'd107;
  // main sequencer: assemble weights/data, settle, capture results and (serial mode) drain them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wi <= '0;
      di <= '0;
      k <= '0;
      cnt <= '0;
      cap <= '0;
      out_busy <= 1'b0;
      data_lin <= '0;
      weight_lin <= '0;
      weight_ok <= 1'b0;
      pic_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= wt_load ? LOAD_W : weight_ok ? LOAD_D : IDLE;
          if (wt_load) weight_ok <= 1'b0;
        end
        LOAD_W: if (in_valid) begin
          weight_lin[wi*8 +: 8] <= in_data;
          wi <= (wi == 5'd26) ? 5'd0 : wi + 5'd1;
          if (wi == 5'd26) begin
            weight_ok <= 1'b1;
            state <= IDLE;
          end
        end
        LOAD_D: if (in_valid) begin
          data_lin[di*8 +: 8] <= in_data;
          di <= di + 6'd1;
          if (di == 6'd63) begin
            cnt <= SW'(SETTLE_CYC - 1);
            state <= WAIT;
          end
        end
`ifdef OVERLAP_EN
        WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        else if (!out_busy) begin
          cap <= conv_lin;
          k <= '0;
          out_busy <= 1'b1;
          state <= IDLE;
        end
`else
        WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          cap <= conv_lin;
          k <= '0;
          state <= DRAIN;
        end
`endif
        DRAIN: if (out_ready) begin
          k <= (k == 7'd107) ? 7'd0 : k + 7'd1;
          if (k == 7'd107) begin
            pic_cnt <= pic_cnt + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef OVERLAP_EN
      if (out_busy && out_ready) begin
        k <= (k == 7'd107) ? 7'd0 : k + 7'd1;
        if (k == 7'd107) begin
          out_busy <= 1'b0;
          pic_cnt <= pic_cnt + 1'b1;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: scoreboard bench for conv_seq_ctrl
module tb_conv_seq_ctrl;
  localparam int SETTLE = 4;
  logic clk = 0, rst = 0, wt_load = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic [863:0] conv_lin = 0;
  logic in_ready, out_valid, out_last, weight_ok, busy;
  logic [511:0] data_lin;
  logic [215:0] weight_lin;
  logic [7:0] out_data;
  logic [15:0] pic_cnt;
  logic [7:0] q[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  conv_seq_ctrl #(.SETTLE_CYC(SETTLE), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .wt_load(wt_load), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .data_lin(data_lin), .weight_lin(weight_lin), .conv_lin(conv_lin),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .weight_ok(weight_ok), .busy(busy), .pic_cnt(pic_cnt)
  );

  function automatic logic [863:0] pat(input logic [7:0] b);
    logic [863:0] p;
    for (int i = 0; i < 108; i++) p[i*8 +: 8] = b + 8'(i);
    return p;
  endfunction

  task automatic push_exp(input logic [7:0] b);
    for (int i = 0; i < 108; i++) q.push_back(b + 8'(i));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    logic r;
    in_valid = 1;
    in_data = b;
    do begin
      r = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 50);
    in_valid = 0;
    tests++;
    if (!r) begin fails++; $display("FAIL send_byte timeout: byte %h not accepted in %0d cycles", b, n); end
  endtask

  task automatic test_reset;
    #1 rst = 1;
    #1;
    tests++;
    if ({in_ready, out_valid, out_last, weight_ok, busy, out_data, pic_cnt} !== '0 || data_lin !== '0 || weight_lin !== '0) begin
      fails++; $display("FAIL reset_outputs: got rdy=%b ov=%b ol=%b wok=%b busy=%b od=%h pic=%0d", in_ready, out_valid, out_last, weight_ok, busy, out_data, pic_cnt);
    end
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 0) begin fails++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_weights;
    wt_load = 1;
    @(posedge clk); #1;
    wt_load = 0;
    for (int j = 0; j < 27; j++) begin
      if (j == 26) begin
        tests++;
        if (weight_ok !== 0) begin fails++; $display("FAIL weight_ok_early: got %b want 0", weight_ok); end
      end
      send_byte(8'(j + 1));
    end
    tests++;
    if (weight_ok !== 1) begin fails++; $display("FAIL weight_ok: got %b want 1", weight_ok); end
    tests++;
    if (weight_lin[7:0] !== 8'h01) begin fails++; $display("FAIL weight_byte0: got %h want 01", weight_lin[7:0]); end
    tests++;
    if (weight_lin[215:208] !== 8'h1B) begin fails++; $display("FAIL weight_byte26: got %h want 1b", weight_lin[215:208]); end
    tests++;
    if (busy !== 0) begin fails++; $display("FAIL weight_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_data_settle;
    conv_lin = pat(8'h80);
    for (int i = 0; i < 64; i++) begin
      send_byte(8'(i));
      if (i % 3 == 2 && i != 63) begin @(posedge clk); #1; end
    end
    tests++;
    if (data_lin[511:504] !== 8'h3F || data_lin[247:240] !== 8'h1E || data_lin[7:0] !== 8'h00) begin
      fails++; $display("FAIL data_lin: got b63=%h b30=%h b0=%h want 3f 1e 00", data_lin[511:504], data_lin[247:240], data_lin[7:0]);
    end
    tests++;
    if (in_ready !== 0 || busy !== 1) begin fails++; $display("FAIL wait_state: rdy=%b busy=%b want 0 1", in_ready, busy); end
    repeat (SETTLE - 1) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 0) begin fails++; $display("FAIL settle_early: out_valid=%b want 0 after %0d edges", out_valid, SETTLE - 1); end
    conv_lin = pat(8'h00);
    push_exp(8'h00);
    @(posedge clk); #1;
    conv_lin = pat(8'h80);
    tests++;
    if (out_valid !== 1) begin fails++; $display("FAIL settle_capture: out_valid=%b want 1 after %0d edges", out_valid, SETTLE); end
  endtask

  task automatic test_drain(input bit toggle, input int exp_cyc, input int exp_pic);
    int n = 0, cyc = 0, h = 0;
    logic v, r, l;
    logic [7:0] d, e;
    while (q.size() > 0 && n < 3000) begin
      out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      v = out_valid; r = out_ready; d = out_data; l = out_last;
      @(posedge clk); #1;
      n++;
      if (v) cyc++;
      if (v && r) begin
        e = q.pop_front();
        tests++;
        if (d !== e) begin fails++; $display("FAIL drain_data: hs %0d got %h want %h", h, d, e); end
        tests++;
        if (l !== (h % 108 == 107)) begin fails++; $display("FAIL drain_last: hs %0d got %b want %b", h, l, h % 108 == 107); end
        h++;
      end else if (v) begin
        tests++;
        if (out_valid !== 1 || out_data !== d) begin fails++; $display("FAIL stall_stable: got v=%b d=%h want 1 %h", out_valid, out_data, d); end
      end
    end
    out_ready = 0;
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL drain_timeout: %0d bytes outstanding", q.size()); end
    tests++;
    if (out_valid !== 0) begin fails++; $display("FAIL drain_end: out_valid=%b want 0", out_valid); end
`ifndef OVERLAP_EN
    tests++;
    if (busy !== 0) begin fails++; $display("FAIL drain_idle: busy=%b want 0", busy); end
`endif
    if (exp_cyc > 0) begin
      tests++;
      if (cyc != exp_cyc) begin fails++; $display("FAIL drain_cycles: got %0d want %0d", cyc, exp_cyc); end
    end
    tests++;
    if (pic_cnt !== 16'(exp_pic)) begin fails++; $display("FAIL pic_cnt: got %0d want %0d", pic_cnt, exp_pic); end
  endtask

  task automatic test_back_to_back;
    conv_lin = pat(8'h40);
    push_exp(8'h40);
    for (int i = 0; i < 64; i++) begin
      send_byte(8'(i) ^ 8'hA5);
      if (i == 0) wt_load = 1;
    end
    wt_load = 0;
    tests++;
    if (weight_ok !== 1 || weight_lin[7:0] !== 8'h01 || data_lin[511:504] !== 8'h9A) begin
      fails++; $display("FAIL wt_load_ignored: wok=%b w0=%h d63=%h want 1 01 9a", weight_ok, weight_lin[7:0], data_lin[511:504]);
    end
    test_drain(1, 216, 2);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 30; i++) send_byte(8'(i + 1));
    in_valid = 1;
    in_data = 8'hFF;
    #2 rst = 1;
    #1;
    tests++;
    if (weight_ok !== 0 || weight_lin !== '0 || data_lin !== '0 || busy !== 0 || in_ready !== 0 || pic_cnt !== 0 || out_valid !== 0) begin
      fails++; $display("FAIL async_reset: wok=%b busy=%b rdy=%b pic=%0d ov=%b", weight_ok, busy, in_ready, pic_cnt, out_valid);
    end
    in_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    wt_load = 0;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (busy !== 0 || in_ready !== 0) begin fails++; $display("FAIL reset_stays_idle: busy=%b rdy=%b want 0 0", busy, in_ready); end
  endtask

`ifdef OVERLAP_EN
  task automatic test_overlap;
    int n = 0;
    test_weights;
    out_ready = 0;
    conv_lin = pat(8'h10);
    push_exp(8'h10);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    tests++;
    if (out_valid !== 1) begin fails++; $display("FAIL overlap_first_capture: out_valid=%b want 1", out_valid); end
    conv_lin = pat(8'h33);
    for (int i = 0; i < 64; i++) send_byte(8'(i) + 8'h70);
    push_exp(8'h33);
    repeat (SETTLE + 6) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1 || out_data !== 8'h10 || busy !== 1) begin
      fails++; $display("FAIL overlap_stall: ov=%b od=%h busy=%b want 1 10 1", out_valid, out_data, busy);
    end
    test_drain(0, 0, 2);
  endtask
`endif

  initial begin
    test_reset;
    test_weights;
    test_data_settle;
    test_drain(0, 108, 1);
    test_back_to_back;
    test_async_reset;
`ifdef OVERLAP_EN
    test_overlap;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
